// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round-constant seed, GF(2^8) doubling,
// round-loop FSM states and the byte-lane helper for 128-bit buses.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Byte k = 4*col + row, most significant byte first.
  function automatic logic [7:0] byte_of(input logic [127:0] v, input int unsigned k);
    return v[127 - 8*k -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 occupies the top byte; row n holds inputs 16n..16n+15.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~a, 3'b111} -: 8];

endmodule

// File: rtl/aes_round_key_add.sv
// Iterative AES-128 AddRoundKey stage with on-the-fly key schedule; one round per clk,
// ciphertext held on a valid/ready output. AES_KEY_SHADOW_EN: buffer key_load while busy.
module aes_round_key_add
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] mix_in,
  input  logic [127:0] end_in,
  output logic [127:0] state_out,
  output logic [3:0]   round,
  output logic         out_valid,
  input  logic         out_ready
);

  aes_state_e   state_q, state_d;
  logic         key_valid_q, key_valid_d;
  logic [127:0] ck_q, ck_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] st_q, st_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
`ifdef AES_KEY_SHADOW_EN
  logic [127:0] shadow_q, shadow_d;
  logic         shadow_pending_q, shadow_pending_d;
`endif

  logic         accept;
  logic [127:0] ck_eff;
  logic [127:0] exp_src;
  logic [7:0]   exp_rc;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] exp_key;

  assign accept = in_valid & in_ready_q;
  // A key loaded in the accepting cycle applies to that very block.
  assign ck_eff = key_load ? key_in : ck_q;

  // One schedule step is shared: the cipher key on accept, the running round key otherwise.
  assign exp_src = (state_q == ST_IDLE) ? ck_eff : rk_q;
  assign exp_rc  = (state_q == ST_IDLE) ? RCON_INIT : rcon_q;

  assign rot_w = {byte_of(exp_src, 13), byte_of(exp_src, 14),
                  byte_of(exp_src, 15), byte_of(exp_src, 12)};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w[31-8*i -: 8]),
      .y (sub_w[31-8*i -: 8])
    );
  end

  assign t_w     = sub_w ^ {exp_rc, 24'h000000};
  assign w0_n    = exp_src[127:96] ^ t_w;
  assign w1_n    = exp_src[95:64]  ^ w0_n;
  assign w2_n    = exp_src[63:32]  ^ w1_n;
  assign w3_n    = exp_src[31:0]   ^ w2_n;
  assign exp_key = {w0_n, w1_n, w2_n, w3_n};

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    ck_d        = ck_q;
    rk_d        = rk_q;
    st_d        = st_q;
    rcon_d      = rcon_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
`ifdef AES_KEY_SHADOW_EN
    shadow_d         = shadow_q;
    shadow_pending_d = shadow_pending_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          ck_d        = key_in;
          key_valid_d = 1'b1;
        end
        if (accept) begin
          st_d    = pt_in ^ ck_eff;
          round_d = 4'd0;
          rk_d    = exp_key;
          rcon_d  = xtime(RCON_INIT);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Final round skips MixColumns, so the ShiftRows-only path is taken.
        st_d    = ((round_q == 4'(NR - 1)) ? end_in : mix_in) ^ rk_q;
        round_d = round_q + 4'd1;
        rk_d    = exp_key;
        rcon_d  = xtime(rcon_q);
        if (round_d == 4'(NR)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AES_KEY_SHADOW_EN
    if (key_load && (state_q != ST_IDLE)) begin
      shadow_d         = key_in;
      shadow_pending_d = 1'b1;
    end
    // The running block keeps its key; a buffered key lands as IDLE is re-entered.
    if ((state_q == ST_DONE) && out_ready && shadow_pending_d) begin
      ck_d             = shadow_d;
      shadow_pending_d = 1'b0;
    end
`endif

    in_ready_d = (state_d == ST_IDLE) && key_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      ck_q        <= '0;
      rk_q        <= '0;
      st_q        <= '0;
      rcon_q      <= RCON_INIT;
      round_q     <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef AES_KEY_SHADOW_EN
      shadow_q         <= '0;
      shadow_pending_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      ck_q        <= ck_d;
      rk_q        <= rk_d;
      st_q        <= st_d;
      rcon_q      <= rcon_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef AES_KEY_SHADOW_EN
      shadow_q         <= shadow_d;
      shadow_pending_q <= shadow_pending_d;
`endif
    end
  end

  assign state_out = st_q;
  assign round     = round_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_aes_round_key_add.sv
// Bench for aes_round_key_add: closes the round loop with a behavioural
// SubBytes/ShiftRows/MixColumns and checks against a FIPS-197 style reference.
module tb_aes_round_key_add;

  localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT0  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT0  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEYB = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk, rst, key_load, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key_in, pt_in, mix_in, end_in, state_out;
  logic [3:0]   round;
  logic         zero_loop;
  int           total, bad;

  aes_round_key_add dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .pt_in(pt_in),
    .mix_in(mix_in), .end_in(end_in), .state_out(state_out),
    .round(round), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv, sq, b;
    inv = 8'h01; sq = a;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[127 - 8*(4*c + r) -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox_ref(gb(s, r, (c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 0, c); a1 = gb(s, 1, c); a2 = gb(s, 2, c); a3 = gb(s, 3, c);
      o[127 - 8*(4*c + 0) -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127 - 8*(4*c + 1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127 - 8*(4*c + 3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0]), sbox_ref(t[31:24])}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ round_key(key, 0);
    for (int r = 1; r < 10; r++) s = mix_cols(sub_shift(s)) ^ round_key(key, r);
    return sub_shift(s) ^ round_key(key, 10);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Neighbouring stages: combinational loop back from state_out.
  logic [127:0] env_sr;
  assign env_sr = sub_shift(state_out);
  assign end_in = zero_loop ? '0 : env_sr;
  assign mix_in = zero_loop ? '0 : mix_cols(env_sr);

  // ---------------- drive helpers (enter and leave at a negedge) ----------------
  task automatic load_key(input logic [127:0] k);
    key_in = k; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic accept_block(input logic [127:0] pt, output int ok);
    pt_in = pt; in_valid = 1'b1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_round(input logic [3:0] r, output int ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (round === r) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (state_out !== 128'h0) begin bad++; $display("FAIL rst_state: got %h want 0", state_out); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL rst_round: got %0d want 0", round); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_key();
    in_valid = 1'b1; pt_in = PT0;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL nokey_in_ready: cycle %0d got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (state_out !== 128'h0 || round !== 4'd0) begin bad++; $display("FAIL nokey_accepted: state %h round %0d want 0/0", state_out, round); end
  endtask

  task automatic test_known_vector();
    int ok, cyc;
    load_key(KEY0);
    accept_block(PT0, ok);
    total++; if (ok != 1) begin bad++; $display("FAIL kv_accept: got no accept want accept"); end
    total++; if (state_out !== R0) begin bad++; $display("FAIL kv_round0: got %h want %h", state_out, R0); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL kv_round_cnt: got %0d want 0", round); end
    wait_valid(cyc);
    total++; if (cyc != 10) begin bad++; $display("FAIL kv_latency: got %0d want 10 cycles after round 0", cyc); end
    total++; if (state_out !== CT0) begin bad++; $display("FAIL kv_ct: got %h want %h", state_out, CT0); end
    total++; if (state_out !== aes_enc(KEY0, PT0)) begin bad++; $display("FAIL kv_ref: got %h want %h", state_out, aes_enc(KEY0, PT0)); end
    total++; if (round !== 4'd10) begin bad++; $display("FAIL kv_round10: got %0d want 10", round); end
    @(negedge clk);
  endtask

  task automatic test_round_keys();
    int ok, cyc;
    logic [127:0] pt;
    pt = rand128();
    zero_loop = 1'b1;
    accept_block(pt, ok);
    total++; if (state_out !== (pt ^ KEY0)) begin bad++; $display("FAIL rk_round0: got %h want %h", state_out, pt ^ KEY0); end
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      total++; if (state_out !== round_key(KEY0, r) || round !== 4'(r)) begin
        bad++; $display("FAIL rk_round%0d: got %h/%0d want %h", r, state_out, round, round_key(KEY0, r));
      end
      if (r == 1) begin
        total++; if (state_out !== RK1) begin bad++; $display("FAIL rk1_const: got %h want %h", state_out, RK1); end
      end
      if (r == 10) begin
        total++; if (state_out !== RK10) begin bad++; $display("FAIL rk10_const: got %h want %h", state_out, RK10); end
      end
    end
    wait_valid(cyc);
    @(negedge clk);
    zero_loop = 1'b0;
  endtask

  task automatic test_backpressure();
    int ok, cyc;
    logic [127:0] pt, exp_ct;
    pt = rand128(); exp_ct = aes_enc(KEY0, pt);
    out_ready = 1'b0;
    accept_block(pt, ok);
    wait_valid(cyc);
    total++; if (cyc != 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", cyc); end
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || state_out !== exp_ct || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: valid %b rdy %b ct %h want 1/0/%h", i, out_valid, in_ready, state_out, exp_ct);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_handshake_cycle: rdy %b valid %b want 0/1", in_ready, out_valid); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_after: rdy %b valid %b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int cyc, outs;
    logic [127:0] pt, exp_ct;
    pt = rand128(); exp_ct = aes_enc(KEY0, pt);
    outs = 0;
    out_ready = 1'b1; pt_in = pt; in_valid = 1'b1;
    for (int c = 0; c < 60 && acc.size() < 3; c++) begin
      if (out_valid === 1'b1) begin
        outs++;
        total++; if (state_out !== exp_ct) begin bad++; $display("FAIL b2b_ct: got %h want %h", state_out, exp_ct); end
      end
      if (in_ready === 1'b1) acc.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (acc.size() != 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", acc.size()); end
    else begin
      total++; if (acc[1] - acc[0] != 12) begin bad++; $display("FAIL b2b_period1: got %0d want 12", acc[1] - acc[0]); end
      total++; if (acc[2] - acc[1] != 12) begin bad++; $display("FAIL b2b_period2: got %0d want 12", acc[2] - acc[1]); end
    end
    total++; if (outs != 2) begin bad++; $display("FAIL b2b_outputs: got %0d want 2", outs); end
    wait_valid(cyc);
    total++; if (state_out !== exp_ct || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_last: got %h want %h", state_out, exp_ct); end
    @(negedge clk);
  endtask

  task automatic test_key_midround();
    int ok, cyc;
    logic [127:0] exp_next;
    load_key(KEY0);
    accept_block(PT0, ok);
    wait_round(4'd4, ok);
    total++; if (ok != 1) begin bad++; $display("FAIL km_reach_r4: round %0d want 4", round); end
    load_key(KEYB);
    wait_valid(cyc);
    total++; if (state_out !== CT0) begin bad++; $display("FAIL km_current: got %h want %h", state_out, CT0); end
    @(negedge clk);
`ifdef AES_KEY_SHADOW_EN
    exp_next = aes_enc(KEYB, PT0);
`else
    exp_next = CT0;
`endif
    accept_block(PT0, ok);
    wait_valid(cyc);
    total++; if (state_out !== exp_next) begin bad++; $display("FAIL km_next: got %h want %h", state_out, exp_next); end
    @(negedge clk);
  endtask

  task automatic test_reset_midround();
    int ok, cyc;
    load_key(KEY0);
    accept_block(PT0, ok);
    wait_round(4'd6, ok);
    rst = 1'b1;
    #1;
    total++; if (state_out !== 128'h0 || round !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs: state %h round %0d valid %b rdy %b want all 0", state_out, round, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; pt_in = PT0;
    for (int i = 0; i < 4; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready: cycle %0d got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (round !== 4'd0 || state_out !== 128'h0) begin bad++; $display("FAIL rstmid_accepted: round %0d state %h want 0", round, state_out); end
    load_key(KEY0);
    accept_block(PT0, ok);
    wait_valid(cyc);
    total++; if (state_out !== CT0) begin bad++; $display("FAIL rstmid_reload: got %h want %h", state_out, CT0); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int ok, cyc, dly;
    logic [127:0] k, pt, exp_ct;
    for (int n = 0; n < 6; n++) begin
      k = rand128(); pt = rand128(); exp_ct = aes_enc(k, pt);
      dly = $urandom_range(0, 3);
      out_ready = (dly == 0);
      if (n % 2 == 0) begin
        load_key(k);
        accept_block(pt, ok);
      end else begin
        // Key load in the accepting cycle: the new key must apply to this block.
        key_in = k; key_load = 1'b1; pt_in = pt; in_valid = 1'b1;
        ok = (in_ready === 1'b1) ? 1 : 0;
        @(negedge clk);
        key_load = 1'b0; in_valid = 1'b0;
      end
      total++; if (ok != 1) begin bad++; $display("FAIL rnd%0d_accept: no accept", n); end
      wait_valid(cyc);
      total++; if (cyc != 10 || state_out !== exp_ct) begin bad++; $display("FAIL rnd%0d_ct: lat %0d got %h want %h", n, cyc, state_out, exp_ct); end
      for (int d = 0; d < dly; d++) @(negedge clk);
      total++; if (out_valid !== 1'b1 || state_out !== exp_ct) begin bad++; $display("FAIL rnd%0d_hold: valid %b got %h want %h", n, out_valid, state_out, exp_ct); end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; pt_in = '0;
    out_ready = 1'b1; zero_loop = 1'b0;
    test_reset();
    test_no_key();
    test_known_vector();
    test_round_keys();
    test_backpressure();
    test_back_to_back();
    test_key_midround();
    test_reset_midround();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/aes_round_key_add.md
# aes_round_key_add

Iterative AddRoundKey stage with an on-the-fly AES-128 key schedule. It closes the round loop: it takes the plaintext in round 0, then takes the ShiftRows/MixColumns outputs (mixed for rounds 1–9, unmixed for round 10) and XORs in the current round key, one round per clock. It registers the state that feeds SubBytes and presents the ciphertext on a valid/ready output.

## Interface
- `NR`, default 10: number of rounds; fixed for AES-128, not otherwise supported.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_load` in 1: capture `key_in` as the cipher key (rules in Operation/Configuration).
- `key_in` in 128: cipher key. Word j is bits [127-32j -: 32].
- `in_valid` in 1: plaintext offered.
- `in_ready` out 1: block can accept plaintext.
- `pt_in` in 128: plaintext.
- `mix_in` in 128: MixColumns result of current round (from the neighbouring stage).
- `end_in` in 128: ShiftRows-only result, used for round 10.
- `state_out` out 128: registered round state, drives SubBytes.
- `round` out 4: round just completed (0..10).
- `out_valid` out 1: ciphertext on `state_out`.
- `out_ready` in 1: consumer takes ciphertext.
- Byte order on all 128-bit buses: byte k = 4*col + row at bits [127-8k -: 8].

## Operation
- FSM states:
  - IDLE: waits for plaintext.
  - RUN: executing rounds.
  - DONE: holding ciphertext.
- `key_valid` flag: cleared by reset, set by the first accepted `key_load`.
- Registers: `ck` (cipher key), `rk` (current round key), `rcon` byte, `round` counter, `st` (state).
- `in_ready` = (IDLE) & `key_valid`.
- Accept (in_valid & in_ready) in IDLE:
  - `st` <= `pt_in ^ ck`, `round` <= 0.
  - `rk` <= expand(`ck`, 01), `rcon` <= 02.
  - Go to RUN.
- RUN, each cycle:
  - `st` <= (`round`==9 ? `end_in` : `mix_in`) ^ `rk`.
  - `round` <= `round` + 1.
  - `rk` <= expand(`rk`, `rcon`), `rcon` <= xtime(`rcon`).
  - When `round` becomes 10, go to DONE.
- Rcon sequence: 01 02 04 08 10 20 40 80 1b 36. xtime = shift left; if bit 7 was set, XOR 0x1b.
- expand(w, rc):
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- DONE: `out_valid`=1 and `state_out` is held. When `out_ready` is seen, go to IDLE with `out_valid` dropped.
  - A new plaintext is accepted at the earliest in the cycle after the DONE→IDLE transition; there is no same-cycle pass-through.
- `key_load` in IDLE: `ck` <= `key_in`, `key_valid` <= 1. If `key_load` and accept happen in the same IDLE cycle, the new key is used for that block.
- Reset mid-round: the block aborts to IDLE and clears all registers and `key_valid`; the key must be reloaded.

## Timing
- Reset values:
  - `state_out`=0, `round`=0, `out_valid`=0, `in_ready`=0.
  - `rk`=0, `ck`=0, `rcon`=01, FSM=IDLE.
- Latency: accept at cycle T gives `round`=0 at T+1 and `out_valid`=1 at T+11.
- The round loop is purely combinational between `state_out` and `mix_in`/`end_in`; the neighbouring stages add no register.
- Throughput: one block per 12 cycles when `out_ready` is held high.
- `out_valid` remains high, with `state_out` stable, until the handshake completes.

## Configuration
- Macro: `AES_KEY_SHADOW_EN`.
- Defined:
  - `key_load` outside IDLE writes a shadow register and sets `shadow_pending`.
  - On entry to IDLE, the shadow is copied to `ck`.
  - The running block always completes with its original key.
- Undefined: `key_load` outside IDLE is ignored.

## Structure
- Package `aes_pkg` holds:
  - the Rcon initial value and the 0x1b polynomial constant;
  - the xtime function;
  - the FSM state enum;
  - the byte-index helper.
- One sub-module, `aes_sbox`: a combinational 8-bit S-box, instantiated 4 times for SubWord.

## Test plan
- Reset, then key 2b7e151628aed2a6abf7158809cf4f3c, then pt 3243f6a8885a308d313198a2e0370734 (loop closed with SubBytes and shiftRow/mixColumn) -> `state_out` at `round`=0 is 193de3bea0f4e22b9ac68d2ae9f84808; `out_valid` at T+11 with 3925841d02dc09fbdc118597196a0b32.
- Same key, `rk` probed -> round-1 key a0fafe1788542cb123a339392a6c7605; round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
- `in_valid` high before any `key_load` -> `in_ready` stays 0 and nothing is accepted.
- `out_ready` held low 5 cycles in DONE -> `out_valid` and the ciphertext stay stable. `in_ready`=0 until one cycle after `out_ready` rises.
- `key_load` of a new key at `round`=4:
  - current block still gives 3925841d…;
  - with `AES_KEY_SHADOW_EN`, the next block uses the new key;
  - without it, the next block uses the old key.
- `rst` asserted at `round`=6 -> all outputs 0 immediately; `in_ready`=0 until the key is reloaded.
